// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Shared definitions for the LED pattern generator. It provides the
//            per-channel mode encoding used on the config bus and inside
//            each channel.
// Contents : MODE_W     - width of the mode field
//            led_mode_t - OFF / ON / BLINK / PWM
// Revision : 1.0  initial release
// ============================================================================
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_t;

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
// Module   : led_channel
// Purpose  : One LED channel. It holds the channel's configured mode and value
//            and its blink state. It produces the next value of the channel's
//            registered LED bit.
// Ports    : aclk      in   clock
//            arstn     in   synchronous active-low reset
//            tick      in   shared prescaler tick (one-cycle pulse)
//            phase     in   shared PWM phase counter
//            wr        in   accepted config write for this channel
//            wr_mode   in   new mode (led_mode_t encoding)
//            wr_value  in   BLINK half-period minus 1, or PWM duty
//            led_next  out  next value of this channel's LED register
// Revision : 1.0  initial release
// ============================================================================
module led_channel
  import led_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic                 tick,
  input  logic [CNT_WIDTH-1:0] phase,
  input  logic                 wr,
  input  logic [MODE_W-1:0]    wr_mode,
  input  logic [CNT_WIDTH-1:0] wr_value,
  output logic                 led_next
);

  led_mode_t            mode;
  logic [CNT_WIDTH-1:0] value;
  logic [CNT_WIDTH-1:0] bcnt;
  logic                 bstate;

  // A write has priority over a coincident tick. The fresh configuration
  // always starts its blink count from zero, with the LED low. Clearing bcnt
  // together with every new value also keeps bcnt at or below value.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      mode   <= MODE_OFF;
      value  <= '0;
      bcnt   <= '0;
      bstate <= 1'b0;
    end else if (wr) begin
      mode   <= led_mode_t'(wr_mode);
      value  <= wr_value;
      bcnt   <= '0;
      bstate <= 1'b0;
    end else if (tick && (mode == MODE_BLINK)) begin
      if (bcnt == value) begin
        bcnt   <= '0;
        bstate <= ~bstate;
      end else begin
        bcnt   <= bcnt + 1'b1;
      end
    end
  end

  always_comb begin
    led_next = 1'b0;
    case (mode)
      MODE_OFF:   led_next = 1'b0;
      MODE_ON:    led_next = 1'b1;
      MODE_BLINK: led_next = bstate;
      MODE_PWM:   led_next = (phase < value);
      default:    led_next = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : Multi-channel LED pattern generator. Each channel is set at
//            runtime to OFF, ON, BLINK or PWM. A shared prescaler tick and a
//            shared PWM phase counter drive all of the channels.
// Ports    : aclk       in   clock
//            arstn      in   synchronous active-low reset
//            cfg_valid  in   config write request
//            cfg_ready  out  config write accept (1 whenever out of reset)
//            cfg_ch     in   target channel (>= NUM_CH is accepted, ignored)
//            cfg_mode   in   0=OFF 1=ON 2=BLINK 3=PWM
//            cfg_value  in   BLINK half-period minus 1, or PWM duty
//            tick       out  prescaler tick pulse
//            led        out  registered LED outputs
// Revision : 1.0  initial release
// ============================================================================
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int CNT_WIDTH = 8,
  parameter int PRESCALE  = 2500,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [MODE_W-1:0]    cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_value,
  output logic                 tick,
  output logic [NUM_CH-1:0]    led
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]      pcnt;
  logic [CNT_WIDTH-1:0] phase;
  logic                 cfg_accept;
  logic [NUM_CH-1:0]    wr;
  logic [NUM_CH-1:0]    led_next;

  // tick is registered from the terminal count. It is therefore high in the
  // cycle after pcnt == PRESCALE-1. With PRESCALE == 1, pcnt stays at 0 and
  // tick stays high continuously.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= (pcnt == PS_LAST) ? '0 : pcnt + 1'b1;
      tick <= (pcnt == PS_LAST);
    end
  end

  // The phase counter advances in tick cycles and wraps naturally.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
    end
  end

  assign cfg_accept = cfg_valid && cfg_ready;

  // An out-of-range cfg_ch matches no channel, so that write is dropped.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr[i] = cfg_accept && (cfg_ch == CH_W'(i));

      led_channel #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_ch (
        .aclk     (aclk),
        .arstn    (arstn),
        .tick     (tick),
        .phase    (phase),
        .wr       (wr[i]),
        .wr_mode  (cfg_mode),
        .wr_value (cfg_value),
        .led_next (led_next[i])
      );
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule
`default_nettype wire
